sprite_fetch_arbiter: RTL and testbench
=======================================

Name: sprite_fetch_arbiter

Overview:
- Shares the single combinational 64x64 sprite texture ROM port between two requesters: the sprite renderer (port A, high priority) and the host/debug readback path (port B, low priority).
- Performs a per-cycle grant with a req/ack handshake and drives the ROM address.
- Registers the ROM data and returns it with a one-cycle-late valid pulse to the granted requester.
- Sits between the row renderer / SPI debug logic and the sprite ROM instance.

Parameters:
- CHANNEL_BITS, 2, bits per colour channel; data width is CHANNEL_BITS*3.
- STARVE_LIMIT, 8, consecutive cycles port B may wait before forced grant (1..255).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- a_req  input  1  renderer request; held until a_ack.
- a_col  input  6  renderer texel column.
- a_row  input  6  renderer texel row.
- a_ack  output  1  one-cycle pulse: A granted this cycle.
- a_valid  output  1  one-cycle pulse: a_data valid (cycle after a_ack).
- a_data  output  CHANNEL_BITS*3  texel returned to A.
- b_req, b_col, b_row, b_ack, b_valid, b_data  (same directions and widths as port A)  host/debug port.
- rom_col  output  6  address column to sprite ROM.
- rom_row  output  6  address row to sprite ROM.
- rom_val  input  CHANNEL_BITS*3  combinational ROM data for rom_col/rom_row.
- b_starved  output  1  high while the starvation counter is at STARVE_LIMIT.

Behaviour:
- Reset (async, reset_n low): a_ack=0, b_ack=0, a_valid=0, b_valid=0, a_data=0, b_data=0, starve counter=0, b_starved=0, last-grant state=GNT_NONE.
- Grant decision is combinational each cycle, from a_req, b_req and the starvation state.
  - Default: A wins whenever a_req=1.
  - B wins if b_req=1 and (a_req=0 or b_starved=1).
- rom_col/rom_row are combinational muxes of the winner's address. With no winner they hold the A address (no glitch requirement).
- a_ack/b_ack are combinational, asserted in the grant cycle T.
- At the clk edge ending cycle T, rom_val is captured into the winner's data register.
- The winner's valid goes high for exactly cycle T+1. Latency from ack to valid is 1 cycle.
- The data register holds its value until that port's next grant. The non-granted port's data is unchanged.
- Requester protocol:
  - Address must be stable while req=1 and ack=0.
  - req sampled high in the cycle after ack counts as a new request, so back-to-back single-cycle fetches are allowed: a throughput of 1 texel/cycle per port.
- Last-grant state register (GNT_NONE/GNT_A/GNT_B), updated every cycle, drives the valid pulses: GNT_A → a_valid, GNT_B → b_valid.
- Starvation counter (8 bit):
  - Increments when b_req=1 and B is not granted; saturates at STARVE_LIMIT.
  - Clears when B is granted or b_req=0.
  - b_starved = (counter == STARVE_LIMIT).
- Simultaneous req with b_starved=1: B granted, A waits exactly one cycle, counter clears.
- Requester dropping req before ack: request abandoned, no ack, no valid. Counter clears if it was B.
- reset_n asserted mid-transfer: pending valid pulse is suppressed; data registers clear to 0.
- Only one ack and at most one valid are high in any cycle.

Optional Feature:
- Macro SPRITE_ARB_FAIRNESS_EN.
- Defined: starvation counter, b_starved and the forced B grant as above.
- Undefined: strict priority; B is granted only when a_req=0; counter logic is removed; b_starved is tied to 0.

Test Plan:
- Reset, then A only: a_req=1, a_col=5, a_row=9, ROM model returns {col,row}-derived value 0x2D → a_ack high in T, a_valid high in T+1 only, a_data=0x2D held afterwards, b_* idle.
- Both requesting one cycle, A held continuously: a_req=1 every cycle, b_req=1 → A granted; with FAIRNESS_EN, B granted at the 9th cycle (counter reaches 8), b_valid on the next cycle, A resumes the cycle after; without the macro B is never granted.
- Back-to-back B fetches, a_req=0: addresses (0,0),(63,63),(1,2) on consecutive cycles → three consecutive b_ack, three consecutive b_valid with matching data, no bubbles.
- Abandoned request: b_req high 3 cycles under A load, then low → no b_ack, counter returns to 0, b_starved stays 0.
- Reset mid-operation: assert reset_n low in the cycle a_ack is high → a_valid never pulses, a_data=0, counter=0; after release the next a_req is served normally.

Source files
------------

// File: rtl/sprite_fetch_arbiter.sv
// Two-port arbiter for the shared combinational sprite texture ROM: renderer (A) over host/debug (B).
// Define SPRITE_ARB_FAIRNESS_EN to enable the B starvation counter and forced B grant.
module sprite_fetch_arbiter #(
   parameter int CHANNEL_BITS = 2,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      a_req,
   input  logic [5:0]                a_col,
   input  logic [5:0]                a_row,
   output logic                      a_ack,
   output logic                      a_valid,
   output logic [CHANNEL_BITS*3-1:0] a_data,
   input  logic                      b_req,
   input  logic [5:0]                b_col,
   input  logic [5:0]                b_row,
   output logic                      b_ack,
   output logic                      b_valid,
   output logic [CHANNEL_BITS*3-1:0] b_data,
   output logic [5:0]                rom_col,
   output logic [5:0]                rom_row,
   input  logic [CHANNEL_BITS*3-1:0] rom_val,
   output logic                      b_starved
);

   typedef enum logic [1:0] {GNT_NONE, GNT_A, GNT_B} gnt_t;

   gnt_t gnt;       // winner of the current cycle
   gnt_t last_gnt;  // winner of the previous cycle, drives the valid pulses

   // Last-grant state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_gnt <= GNT_NONE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         last_gnt <= gnt;
      end
   end

   // Grant decision
   always_comb begin
      // NOTE: default first so no path through the block leaves gnt unassigned (no latch).
      gnt = GNT_NONE;
      if (b_req && (!a_req || b_starved)) begin
         gnt = GNT_B;
      end else if (a_req) begin
         gnt = GNT_A;
      end
   end

   // Outputs: acks and ROM address follow the current winner, valids follow the last one
   always_comb begin
      a_ack   = (gnt == GNT_A);
      b_ack   = (gnt == GNT_B);
      a_valid = (last_gnt == GNT_A);
      b_valid = (last_gnt == GNT_B);
      rom_col = a_col;
      rom_row = a_row;
      if (gnt == GNT_B) begin
         rom_col = b_col;
         rom_row = b_row;
      end
   end

   // Each port's data register only loads on its own grant
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_data <= '0;
         b_data <= '0;
      end else begin
         if (gnt == GNT_A) a_data <= rom_val;
         if (gnt == GNT_B) b_data <= rom_val;
      end
   end

`ifdef SPRITE_ARB_FAIRNESS_EN
   localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

   logic [7:0] starve_cnt;

   // Counts cycles B has been waiting; any gap in b_req forgets the history
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         starve_cnt <= '0;
      end else if (!b_req || gnt == GNT_B) begin
         starve_cnt <= '0;
      end else if (starve_cnt != STARVE_MAX) begin
         starve_cnt <= starve_cnt + 8'd1;
      end
   end

   assign b_starved = (starve_cnt == STARVE_MAX);
`else
   assign b_starved = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Self-checking bench for sprite_fetch_arbiter: vector tables plus a scoreboard of pending read returns.
// Expectations follow SPRITE_ARB_FAIRNESS_EN when the bench is built with it.
module tb_sprite_fetch_arbiter;

   localparam int CB = 2;
   localparam int DW = CB * 3;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          a_req, b_req;
   logic [5:0]    a_col, a_row, b_col, b_row;
   logic          a_ack, a_valid, b_ack, b_valid;
   logic [DW-1:0] a_data, b_data;
   logic [5:0]    rom_col, rom_row;
   logic [DW-1:0] rom_val;
   logic          b_starved;

   typedef struct {
      logic       ar;
      logic [5:0] ac;
      logic [5:0] arow;
      logic       br;
      logic [5:0] bc;
      logic [5:0] brow;
      logic       ea;
      logic       eb;
      logic       es;
   } vec_t;

   typedef struct {
      logic          is_b;
      logic [DW-1:0] data;
   } ret_t;

   vec_t tbl_pre[$];
   vec_t tbl_post[$];
   ret_t sb[$];

   logic [DW-1:0] model_a, model_b;
   int n_cmp = 0;
   int n_bad = 0;

   sprite_fetch_arbiter #(.CHANNEL_BITS(CB), .STARVE_LIMIT(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .a_req(a_req), .a_col(a_col), .a_row(a_row),
      .a_ack(a_ack), .a_valid(a_valid), .a_data(a_data),
      .b_req(b_req), .b_col(b_col), .b_row(b_row),
      .b_ack(b_ack), .b_valid(b_valid), .b_data(b_data),
      .rom_col(rom_col), .rom_row(rom_row), .rom_val(rom_val),
      .b_starved(b_starved)
   );

   always #5 clk = ~clk;

   // ROM model: texel = (col * row) mod 64, so (5,9) -> 0x2D
   function automatic logic [DW-1:0] rom_model(input logic [5:0] c, input logic [5:0] r);
      int p;
      p = (int'(c) * int'(r)) & 63;
      return DW'(p);
   endfunction

   assign rom_val = rom_model(rom_col, rom_row);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(ref vec_t t[$], input logic ar, input int ac, input int arow,
                      input logic br, input int bc, input int brow,
                      input logic ea, input logic eb, input logic es);
      vec_t v;
      v.ar = ar; v.ac = 6'(ac); v.arow = 6'(arow);
      v.br = br; v.bc = 6'(bc); v.brow = 6'(brow);
      v.ea = ea; v.eb = eb; v.es = es;
      t.push_back(v);
   endtask

   task automatic add_idle(ref vec_t t[$]);
      add(t, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // A held with B waiting for 10 cycles
   task automatic add_contention(ref vec_t t[$]);
      for (int i = 1; i <= 10; i++) begin
`ifdef SPRITE_ARB_FAIRNESS_EN
         if (i == 9) add(t, 1, i, 2 * i, 1, 40, 17, 0, 1, 1);
         else        add(t, 1, i, 2 * i, (i < 10), 40, 17, 1, 0, 0);
`else
         add(t, 1, i, 2 * i, 1, 40, 17, 1, 0, 0);
`endif
      end
   endtask

   // One clock cycle: drive, check combinational and registered outputs, record pending returns
   task automatic apply(input vec_t v);
      ret_t r;
      logic exp_av, exp_bv;
      a_req = v.ar; a_col = v.ac; a_row = v.arow;
      b_req = v.br; b_col = v.bc; b_row = v.brow;
      #3;
      check("a_ack", a_ack, v.ea);
      check("b_ack", b_ack, v.eb);
      check("b_starved", b_starved, v.es);
      if (v.ea) check("rom_addr_a", {rom_col, rom_row}, {v.ac, v.arow});
      if (v.eb) check("rom_addr_b", {rom_col, rom_row}, {v.bc, v.brow});
      exp_av = 1'b0;
      exp_bv = 1'b0;
      if (sb.size() > 0) begin
         r = sb.pop_front();
         if (r.is_b) begin exp_bv = 1'b1; model_b = r.data; end
         else        begin exp_av = 1'b1; model_a = r.data; end
      end
      check("a_valid", a_valid, exp_av);
      check("b_valid", b_valid, exp_bv);
      check("a_data", a_data, model_a);
      check("b_data", b_data, model_b);
      if (v.ea) begin r.is_b = 1'b0; r.data = rom_model(v.ac, v.arow); sb.push_back(r); end
      if (v.eb) begin r.is_b = 1'b1; r.data = rom_model(v.bc, v.brow); sb.push_back(r); end
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Pre-reset table: A only, back-to-back B, abandoned B, contention, partial starvation
      add_idle(tbl_pre);
      add(tbl_pre, 1, 5, 9, 0, 0, 0, 1, 0, 0);
      add_idle(tbl_pre);
      add_idle(tbl_pre);
      add(tbl_pre, 0, 5, 9, 1, 0, 0, 0, 1, 0);
      add(tbl_pre, 0, 5, 9, 1, 63, 63, 0, 1, 0);
      add(tbl_pre, 0, 5, 9, 1, 1, 2, 0, 1, 0);
      add_idle(tbl_pre);
      add(tbl_pre, 1, 10, 11, 1, 30, 31, 1, 0, 0);
      add(tbl_pre, 1, 12, 13, 1, 30, 31, 1, 0, 0);
      add(tbl_pre, 1, 14, 15, 1, 30, 31, 1, 0, 0);
      add(tbl_pre, 1, 16, 17, 0, 30, 31, 1, 0, 0);
      add_contention(tbl_pre);
      add_idle(tbl_pre);
      for (int i = 0; i < 4; i++) add(tbl_pre, 1, 20 + i, 3, 1, 50, 51, 1, 0, 0);
      // Post-reset table: counter must start from zero again, then a plain A fetch
      add_idle(tbl_post);
      add_contention(tbl_post);
      add_idle(tbl_post);
      add(tbl_post, 1, 5, 9, 0, 0, 0, 1, 0, 0);
      add_idle(tbl_post);
      add_idle(tbl_post);

      model_a = '0;
      model_b = '0;
      reset_n = 1'b0;
      a_req = 1'b0; a_col = '0; a_row = '0;
      b_req = 1'b0; b_col = '0; b_row = '0;
      @(posedge clk);
      @(negedge clk);
      check("rst_a_ack", a_ack, 1'b0);
      check("rst_b_ack", b_ack, 1'b0);
      check("rst_a_valid", a_valid, 1'b0);
      check("rst_b_valid", b_valid, 1'b0);
      check("rst_a_data", a_data, '0);
      check("rst_b_data", b_data, '0);
      check("rst_b_starved", b_starved, 1'b0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      foreach (tbl_pre[i]) apply(tbl_pre[i]);

      // Reset lands in a cycle where A is being acknowledged
      a_req = 1'b1; a_col = 6'd7; a_row = 6'd3;
      b_req = 1'b1; b_col = 6'd50; b_row = 6'd51;
      #3;
      check("rst_mid_a_ack", a_ack, 1'b1);
      reset_n = 1'b0;
      #1;
      check("rst_mid_a_data", a_data, '0);
      check("rst_mid_b_data", b_data, '0);
      check("rst_mid_b_starved", b_starved, 1'b0);
      @(posedge clk);
      #1;
      check("rst_mid_a_valid", a_valid, 1'b0);
      reset_n = 1'b1;
      sb.delete();
      model_a = '0;
      model_b = '0;

      foreach (tbl_post[i]) apply(tbl_post[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
